ps2_kbd_port: RTL

- Keyboard input stage feeding the CPU's memory-mapped keyboard read at address 14'h1600.
- Receives raw PS/2 frames and checks framing and parity.
- Tracks break/extend prefixes and shift state, translates make codes to ASCII, and buffers characters in a FIFO.
- The CPU pops characters through a one-cycle pop strobe; it replaces the unbuffered fsm path.

---
 rtl/kbd_pkg.sv | 33 +++
 rtl/ps2_kbd_port_if.sv | 10 +
 rtl/ps2_scan2ascii.sv | 74 +++++++
 rtl/ps2_kbd_port.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants and helpers for the PS/2 keyboard port.
package kbd_pkg;

  // Scan-code prefixes and the two shift keys (scan code set 2)
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // Field positions inside the CPU read word at 14'h1600
  localparam int RD_ASCII_LSB = 0;
  localparam int RD_ASCII_MSB = 7;
  localparam int RD_VALID     = 8;
  localparam int RD_OVF       = 9;

  // How the decoder treats an accepted byte
  typedef enum logic [1:0] {
    BK_NORMAL,
    BK_BREAK,
    BK_EXT,
    BK_SHIFT
  } byte_kind_e;

  function automatic byte_kind_e classify_scan(input logic [7:0] code);
    case (code)
      SC_BREAK:             return BK_BREAK;
      SC_EXT:               return BK_EXT;
      SC_LSHIFT, SC_RSHIFT: return BK_SHIFT;
      default:              return BK_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/ps2_kbd_port_if.sv
// CPU-side view of the keyboard port: pop strobe in, read word and status out.
interface ps2_kbd_port_if;
  logic        pop;
  logic [31:0] rd_word;
  logic        not_empty;
  logic        frame_err;

  modport master (output pop, input rd_word, input not_empty, input frame_err);
  modport slave  (input pop, output rd_word, output not_empty, output frame_err);
endinterface

// File: rtl/ps2_scan2ascii.sv
// Scan code set 2 make code to ASCII translation; hit=0 for keys with no character.
module ps2_scan2ascii (
  input  logic [7:0] scan,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       hit
);

  logic [7:0] lo;
  logic [7:0] hi;

  // Table lookup of unshifted and shifted characters
  always_comb begin
    lo  = 8'h00;
    hi  = 8'h00;
    hit = 1'b1;
    case (scan)
      8'h1C: {lo, hi} = "aA";
      8'h32: {lo, hi} = "bB";
      8'h21: {lo, hi} = "cC";
      8'h23: {lo, hi} = "dD";
      8'h24: {lo, hi} = "eE";
      8'h2B: {lo, hi} = "fF";
      8'h34: {lo, hi} = "gG";
      8'h33: {lo, hi} = "hH";
      8'h43: {lo, hi} = "iI";
      8'h3B: {lo, hi} = "jJ";
      8'h42: {lo, hi} = "kK";
      8'h4B: {lo, hi} = "lL";
      8'h3A: {lo, hi} = "mM";
      8'h31: {lo, hi} = "nN";
      8'h44: {lo, hi} = "oO";
      8'h4D: {lo, hi} = "pP";
      8'h15: {lo, hi} = "qQ";
      8'h2D: {lo, hi} = "rR";
      8'h1B: {lo, hi} = "sS";
      8'h2C: {lo, hi} = "tT";
      8'h3C: {lo, hi} = "uU";
      8'h2A: {lo, hi} = "vV";
      8'h1D: {lo, hi} = "wW";
      8'h22: {lo, hi} = "xX";
      8'h35: {lo, hi} = "yY";
      8'h1A: {lo, hi} = "zZ";
      8'h16: {lo, hi} = "1!";
      8'h1E: {lo, hi} = "2@";
      8'h26: {lo, hi} = "3#";
      8'h25: {lo, hi} = "4$";
      8'h2E: {lo, hi} = "5%";
      8'h36: {lo, hi} = "6^";
      8'h3D: {lo, hi} = "7&";
      8'h3E: {lo, hi} = "8*";
      8'h46: {lo, hi} = "9(";
      8'h45: {lo, hi} = "0)";
      8'h29: {lo, hi} = "  ";
      8'h5A: {lo, hi} = {8'h0D, 8'h0D};
      8'h66: {lo, hi} = {8'h08, 8'h08};
      8'h4E: {lo, hi} = "-_";
      8'h55: {lo, hi} = "=+";
      8'h54: {lo, hi} = "[{";
      8'h5B: {lo, hi} = "]}";
      8'h5D: {lo, hi} = "\\|";
      8'h4C: {lo, hi} = ";:";
      8'h52: {lo, hi} = "'\"";
      8'h41: {lo, hi} = ",<";
      8'h49: {lo, hi} = ".>";
      8'h4A: {lo, hi} = "/?";
      8'h0E: {lo, hi} = "`~";
      default: hit = 1'b0;
    endcase
  end

  assign ascii = shift ? hi : lo;

endmodule

// File: rtl/ps2_kbd_port.sv
// PS/2 keyboard receiver, scan-code decoder and character FIFO read by the CPU.
module ps2_kbd_port
  import kbd_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2_clk,
  input  logic          ps2_dat,
  ps2_kbd_port_if.slave cpu
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // Synchronizers and edge detector
  logic clk_s1_q, clk_s2_q, clk_s3_q;
  logic dat_s1_q, dat_s2_q;
  logic fe;

  // Frame receiver state
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [9:0]      frame_q, frame_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_vld_q, byte_vld_d;
  logic            err_q, err_d;

  // Decoder state
  logic brk_q, brk_d;
  logic ext_q, ext_d;
  logic shift_q, shift_d;
  logic push;
  logic [7:0] push_char;
  logic hit;

  // FIFO state
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             do_push, do_pop, full, valid;
  logic [7:0]       head;
  logic [31:0]      rd_word;

  // Bring the PS/2 pins into the clk domain; idle-high reset avoids a false edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= ps2_dat;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fe = clk_s3_q & ~clk_s2_q;

  // Shift in frame bits on each falling edge, check the frame on the stop bit, run the timeout
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    to_d       = to_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;
    if (fe) begin
      to_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        byte_d    = frame_q[8:1];
        if (!frame_q[0] && dat_s2_q && (^frame_q[9:1])) begin
          byte_vld_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        frame_d   = {dat_s2_q, frame_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (to_q == TO_LAST) begin
        to_d      = '0;
        bit_cnt_d = 4'd0;
        err_d     = 1'b1;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end else begin
      to_d = '0;
    end
  end

  // Receiver registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q  <= 4'd0;
      frame_q    <= '0;
      to_q       <= '0;
      byte_q     <= 8'h00;
      byte_vld_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      to_q       <= to_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
      err_q      <= err_d;
    end
  end

  ps2_scan2ascii u_scan2ascii (
    .scan  (byte_q),
    .shift (shift_q),
    .ascii (push_char),
    .hit   (hit)
  );

  // Track break/extend prefixes and shift, and decide whether an accepted byte makes a character
  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    shift_d = shift_q;
    push    = 1'b0;
    if (byte_vld_q) begin
      unique case (classify_scan(byte_q))
        BK_BREAK: brk_d = 1'b1;
        BK_EXT:   ext_d = 1'b1;
        BK_SHIFT: begin
          shift_d = ~brk_q;
          brk_d   = 1'b0;
          ext_d   = 1'b0;
        end
        default: begin
          push  = hit & ~brk_q & ~ext_q;
          brk_d = 1'b0;
          ext_d = 1'b0;
        end
      endcase
    end
  end

  // Decoder registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      shift_q <= 1'b0;
    end else begin
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      shift_q <= shift_d;
    end
  end

  assign valid  = (count_q != '0);
  assign full   = (count_q == CNT_FULL);
  assign do_pop = cpu.pop & valid;
  assign do_push = push & (~full | do_pop);

  // FIFO pointer, occupancy and sticky overflow bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push && full && !do_pop) begin
      ovf_d = 1'b1;
    end else if (do_pop) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Character storage; contents are only observed through count, so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_char;
  end

  assign head = valid ? mem_q[rd_ptr_q] : 8'h00;

  // Assemble the CPU read word
  always_comb begin
    rd_word = 32'h0;
    rd_word[RD_ASCII_MSB:RD_ASCII_LSB] = head;
    rd_word[RD_VALID] = valid;
    rd_word[RD_OVF]   = ovf_q;
  end

  assign cpu.rd_word   = rd_word;
  assign cpu.not_empty = valid;
  assign cpu.frame_err = err_q;

endmodule
